// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage: widths, FSM encodings, alignment helper.
package if_stage_pkg;
  localparam int Addrlen = 32;
  localparam int Instlen = 32;

  localparam logic [0:0] S_FETCH   = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  typedef logic [Addrlen-1:0] addr_t;
  typedef logic [Instlen-1:0] inst_t;

  function automatic addr_t word_align(addr_t a);
    return {a[Addrlen-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: pipeline control from decode/EX, byte-wide memory port, and the IF/ID presentation.
interface if_stage_if;
  import if_stage_pkg::*;
  logic       stall;
  logic       redirect;
  addr_t      redirect_pc;
  logic       mem_req;
  addr_t      mem_addr;
  logic       mem_byte_valid;
  logic [7:0] mem_byte;
  logic       if_valid;
  addr_t      if_pc;
  inst_t      if_inst;

  modport master (
    input  stall, redirect, redirect_pc, mem_byte_valid, mem_byte,
    output mem_req, mem_addr, if_valid, if_pc, if_inst
  );
  modport slave (
    output stall, redirect, redirect_pc, mem_byte_valid, mem_byte,
    input  mem_req, mem_addr, if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/if_stage_icache.sv
// Direct-mapped one-word-per-line instruction cache (built only with ICACHE_EN).
// Addresses are word addresses (pc[31:2]); valid bits clear synchronously on rst.
module if_icache
  import if_stage_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Addrlen-3:0] lookup,
  output logic               hit,
  output inst_t              hit_data,
  input  logic               fill,
  input  logic [Addrlen-3:0] fill_addr,
  input  inst_t              fill_data
);
  localparam int IdxW = $clog2(LINES);
  localparam int TagW = Addrlen - 2 - IdxW;

  logic [LINES-1:0] valid;
  logic [TagW-1:0]  tags [LINES];
  inst_t            data [LINES];
  logic [IdxW-1:0]  lidx, fidx;

  assign lidx     = lookup[IdxW-1:0];
  assign fidx     = fill_addr[IdxW-1:0];
  assign hit      = valid[lidx] && (tags[lidx] == lookup[Addrlen-3:IdxW]);
  assign hit_data = data[lidx];

  always_ff @(posedge clk) begin
    if (rst)       valid       <= '0;
    else if (fill) valid[fidx] <= 1'b1;
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[fidx] <= fill_addr[Addrlen-3:IdxW];
      data[fidx] <= fill_data;
    end
  end
endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: assembles byte-wide memory returns into words for IF/ID.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter addr_t RESET_PC     = 32'h0000_0000,
  parameter int    ICACHE_LINES = 64
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);
  if (ICACHE_LINES < 4 || ICACHE_LINES > 256 ||
      (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two in 4..256");
  end

  logic [0:0]  state;
  addr_t       pc;
  logic [1:0]  cnt;
  logic [23:0] part;
  logic        req_q, valid_q;
  addr_t       ipc_q;
  inst_t       inst_q;
  logic        hit;
  inst_t       hit_data;
  logic        take;

  // A byte counts only while the request is actually being driven.
  assign take          = req_q && bus.mem_byte_valid;
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = pc;
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = ipc_q;
  assign bus.if_inst   = inst_q;

`ifdef ICACHE_EN
  logic fill;
  assign fill = (state == S_FETCH) && !hit && take && (cnt == 2'd3) && !bus.redirect;

  if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk       (clk),
    .rst       (rst),
    .lookup    (pc[Addrlen-1:2]),
    .hit       (hit),
    .hit_data  (hit_data),
    .fill      (fill),
    .fill_addr (pc[Addrlen-1:2]),
    .fill_data ({bus.mem_byte, part})
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= word_align(RESET_PC);
      state   <= S_FETCH;
      cnt     <= 2'd0;
      part    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ipc_q   <= '0;
      inst_q  <= '0;
    end else if (bus.redirect) begin
      // Dropping req for this one cycle is what tells the controller to abort.
      pc      <= word_align(bus.redirect_pc);
      state   <= S_FETCH;
      cnt     <= 2'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (state == S_FETCH) begin
      if (hit) begin
        ipc_q   <= pc;
        inst_q  <= hit_data;
        valid_q <= 1'b1;
        pc      <= pc + 32'd4;
        state   <= S_PRESENT;
        req_q   <= 1'b0;
      end else begin
        req_q <= 1'b1;
        if (take) begin
          if (cnt == 2'd3) begin
            ipc_q   <= pc;
            inst_q  <= {bus.mem_byte, part};
            valid_q <= 1'b1;
            pc      <= pc + 32'd4;
            state   <= S_PRESENT;
            req_q   <= 1'b0;
            cnt     <= 2'd0;
          end else begin
            part[{cnt, 3'b000} +: 8] <= bus.mem_byte;
            cnt                      <= cnt + 2'd1;
          end
        end
      end
    end else if (!bus.stall) begin
      // Consumed this edge: chain straight into the next word on a hit.
      if (hit) begin
        ipc_q  <= pc;
        inst_q <= hit_data;
        pc     <= pc + 32'd4;
      end else begin
        state   <= S_FETCH;
        valid_q <= 1'b0;
        req_q   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus hand sequences for reset, wrap and cache.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        bv;
    logic [7:0]  b;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, d, input logic [31:0] rpc, input logic bv,
                     input logic [7:0] b, input logic req, input logic [31:0] addr,
                     input logic v, input logic [31:0] pc, inst);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = d; x.rpc = rpc; x.bv = bv; x.b = b;
    x.req = req; x.addr = addr; x.v = v; x.pc = pc; x.inst = inst;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.mem_byte_valid = 1'b0; bus.mem_byte = '0;
  endtask

  // Wait (bounded) for a request, then deliver a word little-endian on four consecutive cycles.
  task automatic feed_word(input logic [31:0] w);
    int t = 0;
    while (!bus.mem_req && t < 20) begin
      step();
      t++;
    end
    chk("feed_req", {31'd0, bus.mem_req}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.mem_byte_valid = 1'b1;
      bus.mem_byte       = w[8*k +: 8];
      step();
    end
    bus.mem_byte_valid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc, input logic [31:0] inst);
    chk({nm, "_req"},  {31'd0, bus.mem_req},  {31'd0, req});
    chk({nm, "_addr"}, bus.mem_addr,          addr);
    chk({nm, "_vld"},  {31'd0, bus.if_valid}, {31'd0, v});
    chk({nm, "_pc"},   bus.if_pc,             pc);
    chk({nm, "_inst"}, bus.if_inst,           inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    // reset, first miss (0x00100013 at 0), next fetch address 4
    add(1,0,0,0,0,8'h00, 0,32'h0,0,32'h0,32'h0);
    add(1,0,0,0,1,8'hAA, 0,32'h0,0,32'h0,32'h0);
    add(0,0,0,0,1,8'hAA, 1,32'h0,0,32'h0,32'h0);
    add(0,0,0,0,1,8'h13, 1,32'h0,0,32'h0,32'h0);
    add(0,0,0,0,1,8'h00, 1,32'h0,0,32'h0,32'h0);
    add(0,0,0,0,1,8'h10, 1,32'h0,0,32'h0,32'h0);
    add(0,0,0,0,1,8'h00, 0,32'h4,1,32'h0,32'h0010_0013);
    // consume, fetch pc=4
    add(0,0,0,0,0,8'h00, 1,32'h4,0,32'h0,32'h0010_0013);
    add(0,0,0,0,1,8'h93, 1,32'h4,0,32'h0,32'h0010_0013);
    add(0,0,0,0,1,8'h00, 1,32'h4,0,32'h0,32'h0010_0013);
    add(0,0,0,0,1,8'h20, 1,32'h4,0,32'h0,32'h0010_0013);
    add(0,0,0,0,1,8'h00, 0,32'h8,1,32'h4,32'h0020_0093);
    // consume, fetch pc=8
    add(0,0,0,0,0,8'h00, 1,32'h8,0,32'h4,32'h0020_0093);
    add(0,0,0,0,1,8'h13, 1,32'h8,0,32'h4,32'h0020_0093);
    add(0,0,0,0,1,8'h01, 1,32'h8,0,32'h4,32'h0020_0093);
    add(0,0,0,0,1,8'h30, 1,32'h8,0,32'h4,32'h0020_0093);
    add(0,0,0,0,1,8'h00, 0,32'hC,1,32'h8,32'h0030_0113);
    // stall 3 cycles, stray bytes ignored
    add(0,1,0,0,1,8'hFF, 0,32'hC,1,32'h8,32'h0030_0113);
    add(0,1,0,0,1,8'hFF, 0,32'hC,1,32'h8,32'h0030_0113);
    add(0,1,0,0,1,8'hFF, 0,32'hC,1,32'h8,32'h0030_0113);
    add(0,0,0,0,0,8'h00, 1,32'hC,0,32'h8,32'h0030_0113);
    // two bytes then redirect to 0x1006 with a byte in the redirect cycle
    add(0,0,0,0,1,8'h11, 1,32'hC,0,32'h8,32'h0030_0113);
    add(0,0,0,0,1,8'h22, 1,32'hC,0,32'h8,32'h0030_0113);
    add(0,0,1,32'h1006,1,8'h33, 0,32'h1004,0,32'h8,32'h0030_0113);
    add(0,0,0,0,1,8'h44, 1,32'h1004,0,32'h8,32'h0030_0113);
    add(0,0,0,0,1,8'h01, 1,32'h1004,0,32'h8,32'h0030_0113);
    add(0,0,0,0,1,8'h02, 1,32'h1004,0,32'h8,32'h0030_0113);
    add(0,0,0,0,1,8'h03, 1,32'h1004,0,32'h8,32'h0030_0113);
    add(0,0,0,0,1,8'h04, 0,32'h1008,1,32'h1004,32'h0403_0201);
    // redirect + stall: redirect wins
    add(0,1,1,32'h2000,0,8'h00, 0,32'h2000,0,32'h1004,32'h0403_0201);
    add(0,0,0,0,0,8'h00, 1,32'h2000,0,32'h1004,32'h0403_0201);
    add(0,0,0,0,1,8'h78, 1,32'h2000,0,32'h1004,32'h0403_0201);
    add(0,0,0,0,1,8'h56, 1,32'h2000,0,32'h1004,32'h0403_0201);
    add(0,0,0,0,1,8'h34, 1,32'h2000,0,32'h1004,32'h0403_0201);
    add(0,0,0,0,1,8'h12, 0,32'h2004,1,32'h2000,32'h1234_5678);

    for (int i = 0; i < vecs.size(); i++) begin
      rst                = vecs[i].rst;
      bus.stall          = vecs[i].stall;
      bus.redirect       = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      bus.mem_byte_valid = vecs[i].bv;
      bus.mem_byte       = vecs[i].b;
      step();
      chk_out($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v,
              vecs[i].pc, vecs[i].inst);
    end
    idle();

    // reset mid-miss: burst abandoned, refetch from RESET_PC
    step();
    chk("rm_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_byte_valid = 1'b1; bus.mem_byte = 8'hAB; step();
    bus.mem_byte = 8'hCD; step();
    rst = 1'b1; bus.mem_byte = 8'hEE; step();
    chk_out("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0; bus.mem_byte_valid = 1'b0; step();
    chk("rst_req1", {31'd0, bus.mem_req}, 32'd1);
    chk("rst_addr1", bus.mem_addr, 32'h0);
    feed_word(32'hEFBE_ADDE);
    chk_out("refetch", 1'b0, 32'h4, 1'b1, 32'h0, 32'hEFBE_ADDE);

    // pc wrap at the top of the address space
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF; step();
    bus.redirect = 1'b0;
    chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("wrap_vld", {31'd0, bus.if_valid}, 32'd0);
    feed_word(32'hCAFE_F00D);
    chk_out("wrap", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D);

`ifdef ICACHE_EN
    bus.redirect = 1'b1; bus.redirect_pc = 32'h10; step();
    bus.redirect = 1'b0;
    feed_word(32'h1111_1111);
    chk("c_pc10", bus.if_pc, 32'h10);
    step();
    feed_word(32'h2222_2222);
    chk("c_pc14", bus.if_pc, 32'h14);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h10; step();
    bus.redirect = 1'b0;
    chk_out("c_redir", 1'b0, 32'h10, 1'b0, 32'h14, 32'h2222_2222);
    step();
    chk_out("c_hit10", 1'b0, 32'h14, 1'b1, 32'h10, 32'h1111_1111);
    step();
    chk_out("c_hit14", 1'b0, 32'h18, 1'b1, 32'h14, 32'h2222_2222);
    step();
    chk_out("c_miss18", 1'b1, 32'h18, 1'b0, 32'h14, 32'h2222_2222);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h10 + 32'd4 * 32'd64; step();
    bus.redirect = 1'b0; step();
    chk("c_alias_req", {31'd0, bus.mem_req}, 32'd1);
    chk("c_alias_vld", {31'd0, bus.if_valid}, 32'd0);
    feed_word(32'h3333_3333);
    chk("c_alias_pc", bus.if_pc, 32'h110);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h10; step();
    bus.redirect = 1'b0; step();
    chk("c_evict_req", {31'd0, bus.mem_req}, 32'd1);
    chk("c_evict_vld", {31'd0, bus.if_valid}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RV32I pipeline. Fetches 32-bit instructions over the byte-wide memory-controller port, assembles them little-endian, and presents one instruction with its `pc` per cycle to the IF/ID register that feeds the decoder. It also handles:
- pipeline stalls, including the decoder's load-use stall;
- branch/jump redirects from EX;
- an optional direct-mapped instruction cache.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- ICACHE_LINES, 64, number of one-word cache lines; power of two, 4..256. Used only with ICACHE_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  hold the presented instruction; ready = !stall_i.
- redirect_i  in  1  taken branch/jump from EX; priority over stall_i.
- redirect_pc_i  in  32  new fetch address.
- mem_req_o  out  1  fetch request to memory controller.
- mem_addr_o  out  32  word-aligned fetch address.
- mem_byte_valid_i  in  1  one instruction byte delivered this cycle.
- mem_byte_i  in  8  delivered byte, ascending address order.
- if_valid_o  out  1  if_pc_o/if_inst_o hold a valid instruction.
- if_pc_o  out  32  address of presented instruction.
- if_inst_o  out  32  presented instruction.

## Operation
- Register `pc` holds the next fetch address. Bits [1:0] are forced to 0 on every load, including redirect_pc_i.
- FSM states:
  - FETCH: mem_req_o=1, mem_addr_o=pc. A 2-bit byte counter advances on each mem_byte_valid_i. Byte k is written to inst[8k+7:8k].
    - After the 4th byte: register if_pc_o=pc, if_inst_o=assembled word, if_valid_o=1; pc<=pc+4; go to PRESENT.
  - PRESENT: outputs held.
    - stall_i=0: instruction is consumed that edge. Then either go to FETCH (miss / no cache) or load the next hit directly (cache).
    - stall_i=1: hold everything. mem_req_o=0.
- Redirect in any state: pc<=redirect_pc_i&~3, byte counter<=0, if_valid_o<=0, state<=FETCH.
  - mem_req_o drops for exactly one cycle so the controller aborts its burst.
  - A byte arriving in the redirect cycle is discarded.
- mem_byte_valid_i while mem_req_o=0 is ignored.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset: pc=RESET_PC, state=FETCH, counter=0, if_valid_o=0, if_pc_o=0, if_inst_o=0, mem_req_o=0 for the reset cycle. All cache valid bits are cleared in the same cycle.
- Reset asserted mid-burst abandons the burst. The first request after reset starts at RESET_PC.

## Timing
- mem_req_o rises the cycle after rst falls.
- Miss latency: if_valid_o rises on the edge sampling the 4th mem_byte_valid_i, i.e. controller latency + 4 cycles minimum.
- Cache hit: next instruction is presented on the edge the previous one is consumed. Sustained throughput is 1 instruction/cycle.
- Redirect: if_valid_o low the cycle after redirect_i. First redirected instruction is available after hit (1 cycle) or full miss latency.
- redirect_i and stall_i together: redirect wins; the stalled instruction is dropped.

## Configuration
- ICACHE_EN defined:
  - Direct-mapped cache of ICACHE_LINES words.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = remaining upper bits.
  - Filled with each completed miss word. Lookup happens on pc at the edge entering the next instruction.
  - Hit: no memory request issued.
  - Not flushed except by reset; the pipeline has no self-modifying-code support.
- ICACHE_EN undefined: every instruction takes a full byte fetch; no cache storage is synthesized.

## Structure
- Shared header constants `config.v`:
  - address/instruction widths (Addrlen, Instlen);
  - FSM state encodings;
  - ICACHE_EN default.
- Sub-module `if_icache`: tag/data/valid arrays, combinational hit/data for lookup, write port for fill, synchronous clear on rst. Instantiated only under ICACHE_EN.

## Test plan
- Reset then bytes 13,00,10,00 on four consecutive valid cycles -> if_valid_o=1, if_pc_o=0, if_inst_o=32'h0010_0013; mem_addr_o then 4.
- stall_i=1 for 3 cycles while presenting pc=8 -> outputs frozen, mem_req_o=0; pc=C fetched after release.
- redirect_i with redirect_pc_i=32'h0000_1006 mid-burst (2 bytes in) -> if_valid_o=0 next cycle, mem_req_o low 1 cycle, then mem_addr_o=32'h0000_1004; stale bytes never appear.
- redirect_i and stall_i both high -> stalled instruction dropped, fetch at new target.
- ICACHE_EN: loop 0x10->0x14->redirect 0x10 -> second pass issues no mem_req_o, one instruction per cycle; same-index different-tag address (0x10+4*ICACHE_LINES) misses.
- rst asserted mid-miss -> all outputs at reset values next cycle, cache empty, refetch from RESET_PC.
